// File: rtl/frogger_pkg.sv
// Shared types and defaults for the frogger round/score blocks.
// Optional build macro used by round_ctrl: ROUND_CTRL_PAUSE_EN (adds a pause input).
package frogger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    ALL_HOME,
    LEVEL_UP,
    GAME_OVER
  } round_state_t;

  localparam int ROUND_SECS_DEF = 60;
  localparam int NUM_HOMES_DEF  = 5;
  localparam int MAX_LEVEL_DEF  = 15;

  // Saturating level increment.
  function automatic logic [3:0] lvl_inc(input logic [3:0] l, input int max_lvl);
    return (int'(l) >= max_lvl) ? 4'(max_lvl) : l + 4'd1;
  endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Event/status bundle between the frog logic (master) and round_ctrl (slave).
// With ROUND_CTRL_PAUSE_EN defined the bundle also carries a pause input.
interface round_ctrl_if import frogger_pkg::*; #(
  parameter int NUM_HOMES = NUM_HOMES_DEF
) ();
`ifdef ROUND_CTRL_PAUSE_EN
  logic                 pause;
`endif
  logic                 start;
  logic                 frogDied;
  logic                 frogHome;
  logic [2:0]           homeIdx;
  logic [5:0]           tim;
  logic [3:0]           level;
  logic [1:0]           lives;
  logic [NUM_HOMES-1:0] homesFilled;
  logic                 respawn;
  logic                 allHome;
  logic                 gameOver;

  modport master (
`ifdef ROUND_CTRL_PAUSE_EN
    output pause,
`endif
    output start, frogDied, frogHome, homeIdx,
    input  tim, level, lives, homesFilled, respawn, allHome, gameOver
  );

  modport slave (
`ifdef ROUND_CTRL_PAUSE_EN
    input  pause,
`endif
    input  start, frogDied, frogHome, homeIdx,
    output tim, level, lives, homesFilled, respawn, allHome, gameOver
  );
endinterface

// File: rtl/sec_tick.sv
// One-cycle tick every CLK_HZ enabled cycles; clr restarts the count.
module sec_tick #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(CLK_HZ - 1));

  // Free-running divider; holds while disabled, wraps on tick.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/round_ctrl.sv
// Game-round controller: per-life countdown, lives, homes and level for the
// score block. Build macro ROUND_CTRL_PAUSE_EN adds a pause input that freezes
// the countdown and ignores frog events while in PLAY.
module round_ctrl import frogger_pkg::*; #(
  parameter int CLK_HZ      = 50000000,
  parameter int ROUND_SECS  = ROUND_SECS_DEF,
  parameter int NUM_HOMES   = NUM_HOMES_DEF,
  parameter int START_LIVES = 3,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF
) (
  input  logic         clk,
  input  logic         Reset_n,
  round_ctrl_if.slave  bus
);
  round_state_t         state;
  logic [5:0]           tim_q;
  logic [3:0]           level_q;
  logic [1:0]           lives_q;
  logic [NUM_HOMES-1:0] homes_q, homes_nxt;
  logic                 respawn_q, allhome_q, gameover_q;

  logic       paused, tick, div_clr, div_en;
  logic       start_ok, died, home_ev, slot_bad, home_ok, tmo, death;
  logic [7:0] filled_pad;

`ifdef ROUND_CTRL_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  // Event decode in PLAY: died beats home beats tick; any event discards the tick.
  always_comb begin
    start_ok   = bus.start && (state == IDLE || state == GAME_OVER);
    filled_pad = 8'(homes_q);
    died       = (state == PLAY) && !paused && bus.frogDied;
    home_ev    = (state == PLAY) && !paused && bus.frogHome && !bus.frogDied;
    slot_bad   = (int'(bus.homeIdx) >= NUM_HOMES) || filled_pad[bus.homeIdx];
    home_ok    = home_ev && !slot_bad;
    tmo        = tick && (tim_q == 6'd0) && !bus.frogDied && !bus.frogHome;
    death      = died || (home_ev && slot_bad) || tmo;
    homes_nxt  = homes_q;
    for (int i = 0; i < NUM_HOMES; i++)
      if (bus.homeIdx == 3'(i)) homes_nxt[i] = 1'b1;
    div_en     = (state == PLAY) && !paused;
    div_clr    = start_ok || death || home_ok || state == ALL_HOME || state == LEVEL_UP;
  end

  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clr     (div_clr),
    .en      (div_en),
    .tick    (tick)
  );

  // Round FSM with registered status outputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      tim_q      <= 6'(ROUND_SECS);
      level_q    <= 4'd0;
      lives_q    <= 2'(START_LIVES);
      homes_q    <= '0;
      respawn_q  <= 1'b0;
      allhome_q  <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      allhome_q <= 1'b0;
      case (state)
        IDLE, GAME_OVER: if (start_ok) begin
          state      <= PLAY;
          level_q    <= 4'd1;
          tim_q      <= 6'(ROUND_SECS);
          lives_q    <= 2'(START_LIVES);
          homes_q    <= '0;
          respawn_q  <= 1'b1;
          gameover_q <= 1'b0;
        end
        PLAY: begin
          if (death) begin
            if (lives_q == 2'd1) begin
              lives_q    <= 2'd0;
              state      <= GAME_OVER;
              gameover_q <= 1'b1;
            end else begin
              lives_q   <= lives_q - 2'd1;
              tim_q     <= 6'(ROUND_SECS);
              respawn_q <= 1'b1;
            end
          end else if (home_ok) begin
            homes_q <= homes_nxt;
            if (&homes_nxt) begin
              // Leave tim alone so the score block sees the remaining time.
              state     <= ALL_HOME;
              allhome_q <= 1'b1;
            end else begin
              tim_q     <= 6'(ROUND_SECS);
              respawn_q <= 1'b1;
            end
          end else if (tick) begin
            tim_q <= tim_q - 6'd1;
          end
        end
        ALL_HOME: begin
          state     <= LEVEL_UP;
          level_q   <= lvl_inc(level_q, MAX_LEVEL);
          homes_q   <= '0;
          tim_q     <= 6'(ROUND_SECS);
          respawn_q <= 1'b1;
        end
        LEVEL_UP: state <= PLAY;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.tim         = tim_q;
  assign bus.level       = level_q;
  assign bus.lives       = lives_q;
  assign bus.homesFilled = homes_q;
  assign bus.respawn     = respawn_q;
  assign bus.allHome     = allhome_q;
  assign bus.gameOver    = gameover_q;
endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a fast tick (CLK_HZ=10).
// Expected output snapshots are queued per step and popped against the DUT
// #1 after each rising edge.
module tb_round_ctrl;
  localparam int CLK_HZ = 10;
  localparam int NH     = 5;
  localparam int RS     = 60;
  localparam int ML     = 15;

  logic clk     = 1'b0;
  logic Reset_n = 1'b1;
  always #5 clk = ~clk;

  round_ctrl_if #(.NUM_HOMES(NH)) bus ();

  round_ctrl #(
    .CLK_HZ(CLK_HZ), .ROUND_SECS(RS), .NUM_HOMES(NH), .START_LIVES(3), .MAX_LEVEL(ML)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef enum {S_TIM, S_LVL, S_LIV, S_HOM, S_RSP, S_ALL, S_GO} sig_e;
  typedef struct {
    string       tag;
    sig_e        id;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   e_lvl  = 0;

  function automatic logic [31:0] obs(input sig_e id);
    case (id)
      S_TIM:   return 32'(bus.tim);
      S_LVL:   return 32'(bus.level);
      S_LIV:   return 32'(bus.lives);
      S_HOM:   return 32'(bus.homesFilled);
      S_RSP:   return 32'(bus.respawn);
      S_ALL:   return 32'(bus.allHome);
      default: return 32'(bus.gameOver);
    endcase
  endfunction

  task automatic push(input string tag, input sig_e id, input int val);
    exp_t e;
    e.tag = tag; e.id = id; e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.id);
      n_chk++;
      assert (o === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
    end
  endtask

  task automatic snap(input string t, input int tm, input int lv, input int li,
                      input int hm, input int rs, input int ah, input int go);
    push({t, ".tim"},      S_TIM, tm);
    push({t, ".level"},    S_LVL, lv);
    push({t, ".lives"},    S_LIV, li);
    push({t, ".homes"},    S_HOM, hm);
    push({t, ".respawn"},  S_RSP, rs);
    push({t, ".allHome"},  S_ALL, ah);
    push({t, ".gameOver"}, S_GO,  go);
    check_sb();
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fill all five homes back to back, then check allHome and the level step.
  task automatic complete_level(input int li);
    for (int i = 0; i < NH; i++) begin
      bus.frogHome = 1'b1;
      bus.homeIdx  = 3'(i);
      step();
    end
    bus.frogHome = 1'b0;
    push($sformatf("cl%0d.allHome", e_lvl), S_ALL, 1);
    push($sformatf("cl%0d.homes", e_lvl),   S_HOM, 31);
    push($sformatf("cl%0d.level", e_lvl),   S_LVL, e_lvl);
    check_sb();
    e_lvl = (e_lvl < ML) ? e_lvl + 1 : ML;
    step();
    snap($sformatf("lu%0d", e_lvl), RS, e_lvl, li, 0, 1, 0, 0);
    step();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.frogDied = 1'b0;
    bus.frogHome = 1'b0;
    bus.homeIdx  = 3'd0;
`ifdef ROUND_CTRL_PAUSE_EN
    bus.pause    = 1'b0;
`endif
    #2 Reset_n = 1'b0;
    step(2);
    snap("rst", RS, 0, 3, 0, 0, 0, 0);
    Reset_n = 1'b1;

    // start from IDLE
    bus.start = 1'b1; step(); bus.start = 1'b0;
    snap("start", RS, 1, 3, 0, 1, 0, 0);
    step();
    snap("play", RS, 1, 3, 0, 0, 0, 0);
    step(99);
    snap("t100", 50, 1, 3, 0, 0, 0, 0);

    // homes 0..3, let two ticks pass, then complete with home 4
    for (int i = 0; i < 4; i++) begin
      bus.frogHome = 1'b1; bus.homeIdx = 3'(i); step();
      snap($sformatf("home%0d", i), RS, 1, 3, (1 << (i + 1)) - 1, 1, 0, 0);
    end
    bus.frogHome = 1'b0;
    step(25);
    snap("pre", 58, 1, 3, 15, 0, 0, 0);
    bus.frogHome = 1'b1; bus.homeIdx = 3'd4; step(); bus.frogHome = 1'b0;
    snap("allhome", 58, 1, 3, 31, 0, 1, 0);
    step();
    snap("lvlup", RS, 2, 3, 0, 1, 0, 0);
    step();
    snap("lvl2", RS, 2, 3, 0, 0, 0, 0);

    // duplicate home is a death
    bus.frogHome = 1'b1; bus.homeIdx = 3'd2; step();
    snap("home2", RS, 2, 3, 4, 1, 0, 0);
    step(); bus.frogHome = 1'b0;
    snap("dup", RS, 2, 2, 4, 1, 0, 0);
    step();

    // timeout: tim reaches 0, next tick kills
    step(608);
    snap("t0", 0, 2, 2, 4, 0, 0, 0);
    step();
    snap("tmo", RS, 2, 1, 4, 1, 0, 0);

    // last life: died + home + tick together
    step(9);
    bus.frogDied = 1'b1; bus.frogHome = 1'b1; bus.homeIdx = 3'd0;
    step();
    snap("gover", RS, 2, 0, 4, 0, 0, 1);
    step(30);
    bus.frogDied = 1'b0; bus.frogHome = 1'b0;
    snap("ghold", RS, 2, 0, 4, 0, 0, 1);

    // restart from GAME_OVER
    bus.start = 1'b1; step(); bus.start = 1'b0;
    snap("restart", RS, 1, 3, 0, 1, 0, 0);
    step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    snap("st_play", RS, 1, 3, 0, 0, 0, 0);

    // out-of-range slot is a death
    bus.frogHome = 1'b1; bus.homeIdx = 3'd5; step(); bus.frogHome = 1'b0;
    snap("badidx", RS, 1, 2, 0, 1, 0, 0);
    step();

    // up to level 4, then count down to 23
    e_lvl = 1;
    repeat (3) complete_level(2);
    step(370);
    snap("t23", 23, 4, 2, 0, 0, 0, 0);
`ifdef ROUND_CTRL_PAUSE_EN
    bus.pause = 1'b1; bus.frogDied = 1'b1;
    step(50);
    snap("pause", 23, 4, 2, 0, 0, 0, 0);
    bus.pause = 1'b0; bus.frogDied = 1'b0;
`endif

    // asynchronous reset between edges
    #2 Reset_n = 1'b0;
    #1 snap("arst", RS, 0, 3, 0, 0, 0, 0);
    step();
    Reset_n = 1'b1;

    // level saturation
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    e_lvl = 1;
    repeat (15) complete_level(3);
    snap("sat", RS, ML, 3, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
